// File: rtl/frame_fifo.sv
// Store-and-forward frame FIFO: frames become readable only once their last beat
// lands cleanly; errored or overflowing frames are rolled back and counted.
//
// state  | meaning
// S_IDLE | waiting for the first beat of a frame
// S_RECV | mid-frame, beats written speculatively past wr_commit
// S_DROP | frame already rolled back, discarding beats through in_last
module frame_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic              in_err,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              empty,
  output logic [ADDR_W:0]   frames_stored,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_OCC = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_t;

  logic [DATA_W:0] mem [DEPTH];
  logic [ADDR_W:0] wr_ptr, wr_commit, rd_ptr, commit_q;
  state_t          state, state_nxt;
  logic            err_seen, err_seen_nxt;
  logic            full, do_write, do_commit, do_rollback, load, last_accept;

  assign full        = (wr_ptr - rd_ptr) == FULL_OCC;
  // commit_q adds one cycle so a commit reaches the reader two edges later
  assign load        = (!out_valid || out_ready) && (rd_ptr != commit_q);
  assign last_accept = out_valid && out_ready && out_last;
  assign empty       = (rd_ptr == wr_commit) && !out_valid;

  always_comb begin
    state_nxt    = state;
    err_seen_nxt = err_seen;
    do_write     = 1'b0;
    do_commit    = 1'b0;
    do_rollback  = 1'b0;
    if (in_valid) begin
      case (state)
        S_IDLE, S_RECV: begin
          if (full) begin
            do_rollback  = 1'b1;
            err_seen_nxt = 1'b0;
            state_nxt    = in_last ? S_IDLE : S_DROP;
          end else begin
            do_write = 1'b1;
            if (in_last) begin
              if (in_err || (state == S_RECV && err_seen)) do_rollback = 1'b1;
              else                                         do_commit   = 1'b1;
              err_seen_nxt = 1'b0;
              state_nxt    = S_IDLE;
            end else begin
              err_seen_nxt = in_err || (state == S_RECV && err_seen);
              state_nxt    = S_RECV;
            end
          end
        end
        S_DROP: if (in_last) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_write && !rst) mem[wr_ptr[ADDR_W-1:0]] <= {in_last, in_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      err_seen      <= 1'b0;
      wr_ptr        <= '0;
      wr_commit     <= '0;
      rd_ptr        <= '0;
      commit_q      <= '0;
      frame_cnt     <= '0;
      drop_cnt      <= '0;
      frames_stored <= '0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
    end else begin
      state    <= state_nxt;
      err_seen <= err_seen_nxt;
      commit_q <= wr_commit;

      if (do_rollback)   wr_ptr <= wr_commit;
      else if (do_write) wr_ptr <= wr_ptr + 1'b1;

      if (do_commit) begin
        wr_commit <= wr_ptr + 1'b1;
        if (frame_cnt != {CNT_W{1'b1}}) frame_cnt <= frame_cnt + 1'b1;
      end
      if (do_rollback && drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;

      case ({do_commit, last_accept})
        2'b10:   frames_stored <= frames_stored + 1'b1;
        2'b01:   frames_stored <= frames_stored - 1'b1;
        default: frames_stored <= frames_stored;
      endcase

      if (load) begin
        {out_last, out_data} <= mem[rd_ptr[ADDR_W-1:0]];
        out_valid            <= 1'b1;
        rd_ptr               <= rd_ptr + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/frame_fifo.md
Name: frame_fifo

Overview:
- Parametrised, frame-aware successor to the plain byte FIFO between the MAC RX and TX paths.
- Stores complete Ethernet frames (data plus end-of-frame marker) in store-and-forward mode.
- A frame is released to the reader only after its last beat is accepted without error. Errored and overflowing frames are rolled back and counted.
- Sits in the rx_mac_clk domain between mac_controller RX output and TX input, single clock.

Parameters:
- DATA_W, 8, width of one data beat.
- ADDR_W, 9, log2 of storage depth in beats (depth 512).
- CNT_W, 16, width of the frame and drop statistics counters.

Ports:
- clk  input  1  block clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  receive beat.
- in_valid  input  1  in_data valid this cycle; no backpressure, so the writer never stalls.
- in_last  input  1  qualifies the final beat of a frame; sampled only with in_valid.
- in_err  input  1  frame error (PHY rx_err / bad FCS); sampled with in_valid; any errored beat poisons the frame.
- out_data  output  DATA_W  transmit beat.
- out_valid  output  1  out_data holds a committed beat.
- out_last  output  1  final beat of the frame on out_data.
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready.
- empty  output  1  no committed beats remain.
- frames_stored  output  ADDR_W+1  committed frames not yet fully read.
- frame_cnt  output  CNT_W  frames committed since reset; saturating.
- drop_cnt  output  CNT_W  frames dropped since reset; saturating.

Behaviour:
- Storage: array of 2^ADDR_W entries, each DATA_W+1 bits (data, last flag).
- Pointers are ADDR_W+1 bits: wr_ptr (speculative), wr_commit, rd_ptr.
- occupancy = wr_ptr - rd_ptr; full when occupancy = 2^ADDR_W, using pointer values at cycle start.
- Reset: all pointers 0, write FSM to IDLE, all counters 0. Outputs: out_valid=0, out_last=0, out_data=0, empty=1, frames_stored=0.
  - Reset mid-frame discards the partial frame.
  - Beats arriving after reset are treated as a new frame.
- Write FSM:
  - IDLE: in_valid → write the beat, wr_ptr+1.
    - If in_last, commit immediately (single-beat frame), else go to RECV.
    - If in_err && in_last, roll back instead.
  - RECV: each in_valid beat is written and wr_ptr increments. On the in_last beat:
    - Frame clean: wr_commit ← wr_ptr+1, frame_cnt+1, go to IDLE.
    - Any beat of the frame had in_err: wr_ptr ← wr_commit, drop_cnt+1, go to IDLE.
  - Overflow: in_valid while full (IDLE or RECV) → beat not written, wr_ptr ← wr_commit, drop_cnt+1.
    - Go to DROP, or directly to IDLE if that beat is in_last.
  - DROP: discard all beats through in_last, then go to IDLE. No counter change on exit.
  - Frames longer than 2^ADDR_W beats are always dropped.
- Read side:
  - Readable when rd_ptr != wr_commit; a one-entry output register feeds out_data, out_valid and out_last.
  - Latency: in_last committed at edge N → first beat presented with out_valid=1 after edge N+2.
  - Holding: out_data, out_valid and out_last stay stable while out_valid && !out_ready.
  - Throughput: back-to-back one beat per cycle while out_ready=1 and committed data remain.
  - Frame release: frames_stored decrements when a beat with out_last is accepted and increments on commit. Simultaneous commit and last-accept leave it unchanged.
- Simultaneous events: a read freeing space in the same cycle as a write at full does not prevent overflow, because full is evaluated at cycle start. Rollback never moves wr_ptr below rd_ptr, since wr_commit ≥ rd_ptr always holds.
- Pointer wrap: pointers wrap modulo 2^(ADDR_W+1); full/empty remain correct across wrap.
- empty = (rd_ptr == wr_commit) && !out_valid.

Test Plan:
- Clean frame: 64-beat frame 0x00..0x3F, out_ready=1 → out_valid rises 2 cycles after in_last. 64 beats match in order, out_last on 0x3F, frame_cnt=1, frames_stored returns to 0, empty=1.
- Errored frame: 20-beat frame with in_err on beat 10, then a clean 8-beat frame → only the 8 beats are output; drop_cnt=1, frame_cnt=1.
- Overflow: ADDR_W=4, out_ready=0, 10-beat frame then 10-beat frame → first stored, second dropped (drop_cnt=1). Then out_ready=1 → exactly 10 beats output and empty=1.
- Backpressure: 3 committed 5-beat frames, out_ready toggled 1/0 every cycle → 15 beats, no duplication or loss; out_data stable while stalled; frames_stored steps 3→2→1→0.
- Wrap: ADDR_W=4, 40 consecutive 7-beat frames read concurrently → all 280 beats correct; frame_cnt=40, drop_cnt=0.
- Reset mid-frame: rst for 1 cycle after beat 5 of a 12-beat frame, then a 4-beat frame → out_valid=0 during reset; the 7-beat tail is output as one frame, then the 4-beat frame; frame_cnt=2.
